// File: rtl/result_collector_if.sv
// Head-of-FIFO valid/ready handshake between result_collector and its consumer.
interface result_collector_if #(
    parameter int unsigned WIDTH = 32
);
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic [2:0]       m_tag;

    modport master (output m_valid, m_data, m_tag, input m_ready);
    modport slave  (input m_valid, m_data, m_tag, output m_ready);
endinterface

// File: rtl/result_collector.sv
// Collects upstream mux results (one cycle behind their select) into a
// first-word-fall-through FIFO tagged with the select that produced them.
module result_collector #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cap_en,
    input  logic [2:0]               sel,
    input  logic [WIDTH-1:0]         res_in,
    result_collector_if.master       m,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [7:0]               drop_cnt,
    output logic                     illegal
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic             cap_d;
    logic [2:0]       sel_d;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] data_mem [DEPTH];
    logic [2:0]       tag_mem  [DEPTH];
    logic             pop;
    logic             push_acc;
    logic             push_rej;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);

    assign m.m_valid = !empty;
    assign m.m_data  = data_mem[rd_ptr];
    assign m.m_tag   = tag_mem[rd_ptr];

    // A full FIFO still accepts when the head leaves on the same edge.
    assign pop      = m.m_valid && m.m_ready;
    assign push_acc = cap_d && (!full || pop);
    assign push_rej = cap_d && full && !pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_d    <= 1'b0;
            sel_d    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
            illegal  <= 1'b0;
        end else begin
            cap_d <= cap_en;
            sel_d <= sel;
            if (push_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (sel_d > 3'd4) begin
                    illegal <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_acc && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push_acc) begin
                count <= count - (AW+1)'(1);
            end
            if (push_rej && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // Storage is deliberately left out of reset; contents are only visible when m_valid.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            data_mem[wr_ptr] <= res_in;
            tag_mem[wr_ptr]  <= sel_d;
        end
    end
endmodule

// File: tb/tb_result_collector.sv
// Randomized bench for result_collector against a queue-based reference model.
module tb_result_collector;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned WIDTH = 32;

    typedef struct {
        logic [2:0]       tag;
        logic [WIDTH-1:0] data;
    } ent_t;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic                    cap_en = 1'b0;
    logic [2:0]              sel = '0;
    logic [WIDTH-1:0]        res_in = '0;
    logic [$clog2(DEPTH):0]  count;
    logic                    full;
    logic                    empty;
    logic [7:0]              drop_cnt;
    logic                    illegal;

    result_collector_if #(.WIDTH(WIDTH)) mif ();

    result_collector #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .cap_en   (cap_en),
        .sel      (sel),
        .res_in   (res_in),
        .m        (mif),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .drop_cnt (drop_cnt),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    // Reference model state
    ent_t        q[$];
    logic        cap_d_m = 1'b0;
    logic [2:0]  sel_d_m = '0;
    int unsigned drop_m = 0;
    logic        ill_m = 1'b0;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("m_valid", 64'(mif.m_valid), 64'(q.size() != 0));
        check("count", 64'(count), 64'(q.size()));
        check("full", 64'(full), 64'(q.size() == DEPTH));
        check("empty", 64'(empty), 64'(q.size() == 0));
        check("drop_cnt", 64'(drop_cnt), 64'(drop_m));
        check("illegal", 64'(illegal), 64'(ill_m));
        if (q.size() != 0) begin
            check("m_data", 64'(mif.m_data), 64'(q[0].data));
            check("m_tag", 64'(mif.m_tag), 64'(q[0].tag));
        end
    endtask

    task automatic model_edge(input logic ce, input logic [2:0] s, input logic [WIDTH-1:0] r,
                              input logic rdy);
        int unsigned occ;
        bit pop_m;
        ent_t e;
        occ   = q.size();
        pop_m = (occ != 0) && rdy;
        if (pop_m) void'(q.pop_front());
        if (cap_d_m) begin
            if (occ < DEPTH || pop_m) begin
                e.tag  = sel_d_m;
                e.data = r;
                q.push_back(e);
                if (sel_d_m > 3'd4) ill_m = 1'b1;
            end else if (drop_m < 255) begin
                drop_m++;
            end
        end
        cap_d_m = ce;
        sel_d_m = s;
    endtask

    // One clock: check state at negedge, drive inputs, advance model at posedge.
    task automatic step(input logic ce, input logic [2:0] s, input logic [WIDTH-1:0] r,
                        input logic rdy);
        check_outputs();
        cap_en      = ce;
        sel         = s;
        res_in      = r;
        mif.m_ready = rdy;
        @(posedge clk);
        model_edge(ce, s, r, rdy);
        @(negedge clk);
    endtask

    task automatic async_reset();
        #2;
        cap_en      = 1'b0;
        mif.m_ready = 1'b0;
        reset       = 1'b1;
        #1;
        check("rst_m_valid", 64'(mif.m_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        check("rst_illegal", 64'(illegal), 64'd0);
        q.delete();
        cap_d_m = 1'b0;
        sel_d_m = '0;
        drop_m  = 0;
        ill_m   = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH + 2; i++) begin
            if (q.size() != 0 || cap_d_m) step(1'b0, 3'd0, WIDTH'($urandom), 1'b1);
        end
        check("drain_empty", 64'(empty), 64'd1);
    endtask

    task automatic fill(input int unsigned n);
        for (int i = 0; i < n; i++) step(1'b1, 3'($urandom_range(0, 4)), WIDTH'($urandom), 1'b0);
        step(1'b0, 3'd0, WIDTH'($urandom), 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mif.m_ready = 1'b0;
        async_reset();

        // Single capture latency
        step(1'b1, 3'd2, WIDTH'($urandom), 1'b0);
        step(1'b0, 3'd0, 32'h0000_0007, 1'b0);
        check("lat_valid", 64'(mif.m_valid), 64'd1);
        check("lat_tag", 64'(mif.m_tag), 64'd2);
        check("lat_data", 64'(mif.m_data), 64'h7);
        check("lat_count", 64'(count), 64'd1);
        drain();

        // Overfill by one, then drain in order
        fill(9);
        check("ovf_count", 64'(count), 64'd8);
        check("ovf_full", 64'(full), 64'd1);
        check("ovf_drop", 64'(drop_cnt), 64'd1);
        drain();

        // Push into full FIFO while the head is popped on the same edge
        fill(8);
        step(1'b1, 3'd3, WIDTH'($urandom), 1'b0);
        step(1'b0, 3'd0, 32'hCAFE_0033, 1'b1);
        check("pp_count", 64'(count), 64'd8);
        check("pp_drop", 64'(drop_cnt), 64'd1);
        check("pp_tail_tag", 64'(q[DEPTH-1].tag), 64'd3);
        drain();

        // Illegal tag is stored and sticky
        step(1'b1, 3'd6, WIDTH'($urandom), 1'b0);
        step(1'b0, 3'd0, WIDTH'($urandom), 1'b0);
        check("ill_flag", 64'(illegal), 64'd1);
        check("ill_tag", 64'(mif.m_tag), 64'd6);
        drain();
        check("ill_sticky", 64'(illegal), 64'd1);

        // Drop counter saturation
        for (int i = 0; i < 310; i++) step(1'b1, 3'($urandom_range(0, 4)), WIDTH'($urandom), 1'b0);
        check("sat_drop", 64'(drop_cnt), 64'd255);
        drain();

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 99) < 60), 3'($urandom), WIDTH'($urandom),
                 1'($urandom_range(0, 99) < 50));
        end
        drain();

        // Reset with 5 stored entries and one capture in flight
        for (int i = 0; i < 6; i++) step(1'b1, 3'($urandom_range(0, 4)), WIDTH'($urandom), 1'b0);
        check("pre_rst_count", 64'(count), 64'd5);
        async_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 3'd0, WIDTH'($urandom), 1'b1);
            check("post_rst_empty", 64'(empty), 64'd1);
        end
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning FIFO entries (power of two, >=2).
REQ-002 The block SHALL have parameter WIDTH, default 32, meaning result data width.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state on rising edge.
REQ-004 The block SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-005 The block SHALL have port cap_en, input, 1, meaning capture request, asserted in the same cycle sel is presented to the upstream result mux.
REQ-006 The block SHALL have port sel, input, 3, meaning the select presented upstream that cycle.
REQ-007 The block SHALL have port res_in, input, WIDTH, meaning the upstream registered result (one-cycle latency from sel).
REQ-008 The block SHALL have port m_valid, output, 1, meaning head entry available.
REQ-009 The block SHALL have port m_ready, input, 1, meaning consumer accepts head entry.
REQ-010 The block SHALL have port m_data, output, WIDTH, meaning head entry result.
REQ-011 The block SHALL have port m_tag, output, 3, meaning head entry sel tag.
REQ-012 The block SHALL have port count, output, log2(DEPTH)+1, meaning current occupancy.
REQ-013 The block SHALL have ports full and empty, output, 1 each, meaning count==DEPTH and count==0.
REQ-014 The block SHALL have port drop_cnt, output, 8, meaning saturating count of dropped captures.
REQ-015 The block SHALL have port illegal, output, 1, meaning sticky flag: a tag >4 was captured.

Function
REQ-016 Alignment stage: cap_d<=cap_en and sel_d<=sel every cycle, so res_in is paired with the sel that produced it.
REQ-017 Push condition: cap_d==1; entry {sel_d, res_in} written at rising edge.
REQ-018 Push accepted when !full, or when full and a pop occurs in the same cycle.
REQ-019 Pop condition: m_valid && m_ready; read pointer advances at rising edge.
REQ-020 First-word fall-through: m_valid=!empty; m_data/m_tag show the head entry combinationally from storage.
REQ-021 Latency: cap_en high in cycle N -> entry written at end of N+1 -> m_valid high in cycle N+2 (FIFO previously empty).
REQ-022 Simultaneous push and pop: count unchanged; both pointers advance.
REQ-023 Pop with empty is impossible (m_valid low); m_ready ignored when empty.
REQ-024 Pointers wrap modulo DEPTH; count tracks occupancy 0..DEPTH exactly.
REQ-025 Rejected push (full, no pop): entry discarded; drop_cnt increments, saturating at 255.
REQ-026 illegal set at any accepted push with sel_d in 5..7; stays set until reset; entry still stored.
REQ-027 m_data/m_tag SHALL be held stable while m_valid && !m_ready.

Reset
REQ-028 On reset assertion, immediately: pointers=0, count=0, empty=1, full=0, m_valid=0, cap_d=0, sel_d=0, drop_cnt=0, illegal=0.
REQ-029 Reset mid-operation discards all stored and in-flight entries; first push possible only from cap_en sampled after deassertion.
REQ-030 m_data/m_tag are don't-care while m_valid=0; storage array not reset.

Verification
REQ-031 cap_en=1,sel=2 in cycle 0; res_in=0x0000_0007 in cycle 1 -> cycle 2: m_valid=1, m_tag=2, m_data=0x7, count=1.
REQ-032 9 consecutive captures, m_ready=0 -> count=8, full=1, drop_cnt=1; draining returns first 8 in order.
REQ-033 Full FIFO, capture with m_ready=1 same cycle -> count stays 8, drop_cnt unchanged, new entry at tail.
REQ-034 Capture with sel=6 -> illegal=1, m_tag=6; illegal remains 1 after drain until reset.
REQ-035 300 captures into full FIFO, no pops -> drop_cnt=255.
REQ-036 Assert reset with 5 entries and cap_d=1 -> m_valid=0, count=0 immediately; no entry appears after release without new cap_en.
